coin_acceptor: RTL and testbench

- Front-end stage directly upstream of the vending machine controller.
- Synchronises and debounces the two raw coin-slot sensors (nickel, dime) and rejects glitches, dual-sensor events and coins offered while disabled.
- Detects jammed coins.
- Emits a clean one-cycle coin code on the 2-bit coin bus that the controller consumes. The bus encoding is 0 none, 1 nickel, 2 dime; 3 is never driven.

---
 rtl/coin_acceptor.sv | 164 ++++++++++++++++
 tb/tb_coin_acceptor.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronises and debounces the nickel/dime sensors, detects jams,
// and issues a single registered coin-or-reject pulse per physical insertion.
module coin_acceptor #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned JAM_CYCLES      = 64,
    parameter int unsigned CNT_W           = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       nickel_sense,
    input  logic       dime_sense,
    input  logic       enable,
    input  logic       clear_jam,
    output logic [1:0] coin,
    output logic       reject,
    output logic       jam,
    output logic [7:0] accepted_count
);

    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_DEBOUNCE     = 3'd1;
    localparam logic [2:0] ST_HOLD         = 3'd2;
    localparam logic [2:0] ST_WAIT_RELEASE = 3'd3;
    localparam logic [2:0] ST_JAM          = 3'd4;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] JAM_LAST = CNT_W'(JAM_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [1:0] raw_sense;
    logic [1:0] synced;
    logic       ns;
    logic       ds;

    assign raw_sense = {dime_sense, nickel_sense};

    // Bit 0 is the nickel channel, bit 1 the dime channel.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= raw_sense[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign synced[gi] = sync_reg;
        end
    endgenerate

    assign ns = synced[0];
    assign ds = synced[1];

    logic [2:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             chan_reg, chan_next;
    logic [1:0]       coin_reg, coin_next;
    logic             reject_reg, reject_next;
    logic             jam_reg;
    logic [7:0]       count_reg, count_next;

    logic             latched;
    logic             other;
    logic [CNT_W-1:0] cnt_sat;

    // chan_reg: 0 = nickel latched, 1 = dime latched.
    assign latched = chan_reg ? ds : ns;
    assign other   = chan_reg ? ns : ds;
    assign cnt_sat = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        chan_next   = chan_reg;
        coin_next   = 2'd0;
        reject_next = 1'b0;
        count_next  = count_reg;
        case (state_reg)
            ST_IDLE: begin
                if (ns ^ ds) begin
                    chan_next  = ds;
                    cnt_next   = {{(CNT_W-1){1'b0}}, 1'b1};
                    state_next = ST_DEBOUNCE;
                end else if (ns & ds) begin
                    reject_next = 1'b1;
                    state_next  = ST_WAIT_RELEASE;
                end
            end
            ST_DEBOUNCE: begin
                if (!latched) begin
                    state_next = ST_IDLE;
                end else if (other) begin
                    reject_next = 1'b1;
                    state_next  = ST_WAIT_RELEASE;
                end else begin
                    if (cnt_reg == DEB_LAST) begin
                        if (enable) begin
                            coin_next  = chan_reg ? 2'd2 : 2'd1;
                            count_next = count_reg + 8'd1;
                        end else begin
                            reject_next = 1'b1;
                        end
                        state_next = ST_HOLD;
                    end
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_HOLD: begin
                if (!(ns | ds)) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_sat;
                    if (cnt_sat >= JAM_LAST) begin
                        state_next = ST_JAM;
                    end
                end
            end
            ST_WAIT_RELEASE: begin
                if (!(ns | ds)) begin
                    state_next = ST_IDLE;
                end
            end
            ST_JAM: begin
                // Only a clear with the slot physically empty releases the jam.
                if (clear_jam && !(ns | ds)) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            chan_reg   <= 1'b0;
            coin_reg   <= 2'd0;
            reject_reg <= 1'b0;
            jam_reg    <= 1'b0;
            count_reg  <= 8'd0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            chan_reg   <= chan_next;
            coin_reg   <= coin_next;
            reject_reg <= reject_next;
            jam_reg    <= (state_next == ST_JAM);
            count_reg  <= count_next;
        end
    end

    assign coin           = coin_reg;
    assign reject         = reject_reg;
    assign jam            = jam_reg;
    assign accepted_count = count_reg;

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed scenarios plus random insertions, every cycle
// compared against an insertion-level reference model.
module tb_coin_acceptor;

    localparam int DEB = 4;
    localparam int JAMC = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       nickel_sense = 1'b0;
    logic       dime_sense = 1'b0;
    logic       enable = 1'b1;
    logic       clear_jam = 1'b0;
    logic [1:0] coin;
    logic       reject;
    logic       jam;
    logic [7:0] accepted_count;

    int checks = 0;
    int failures = 0;
    int n_coin = 0;
    int n_rej = 0;

    coin_acceptor #(.DEBOUNCE_CYCLES(DEB), .JAM_CYCLES(JAMC), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .nickel_sense(nickel_sense), .dime_sense(dime_sense),
        .enable(enable), .clear_jam(clear_jam), .coin(coin), .reject(reject),
        .jam(jam), .accepted_count(accepted_count)
    );

    always #5 clk = ~clk;

    // Reference model: sensors seen two cycles late; an insertion is tracked by its age.
    bit m_s1n, m_s1d, m_s2n, m_s2d;
    bit m_busy, m_decided, m_dime, m_jammed;
    int m_age;
    int m_coin, m_rej, m_count;

    task automatic model(input bit rn, input bit rd, input bit en, input bit clr, input bit rs);
        bit sn, sd, own, oth;
        if (rs) begin
            {m_s1n, m_s1d, m_s2n, m_s2d} = '0;
            m_busy = 0; m_decided = 0; m_dime = 0; m_jammed = 0;
            m_age = 0; m_coin = 0; m_rej = 0; m_count = 0;
            return;
        end
        sn = m_s2n; sd = m_s2d;
        m_coin = 0; m_rej = 0;
        if (m_jammed) begin
            if (clr && !(sn || sd)) m_jammed = 0;
        end else if (!m_busy) begin
            if (sn && sd) begin
                m_rej = 1; m_busy = 1; m_decided = 1; m_age = 0;
            end else if (sn || sd) begin
                m_busy = 1; m_decided = 0; m_dime = sd; m_age = 1;
            end
        end else if (!m_decided) begin
            own = m_dime ? sd : sn;
            oth = m_dime ? sn : sd;
            if (!own) m_busy = 0;
            else if (oth) begin
                m_rej = 1; m_decided = 1; m_age = 0;
            end else begin
                m_age++;
                if (m_age == DEB) begin
                    m_decided = 1;
                    if (en) begin
                        m_coin = m_dime ? 2 : 1;
                        m_count = (m_count + 1) % 256;
                    end else m_rej = 1;
                end
            end
        end else begin
            // age 0 marks a dual-sensor reject that only waits for release
            if (!(sn || sd)) m_busy = 0;
            else if (m_age != 0) begin
                if (m_age < 255) m_age++;
                if (m_age >= JAMC - 1) begin
                    m_jammed = 1; m_busy = 0;
                end
            end
        end
        m_s2n = m_s1n; m_s2d = m_s1d;
        m_s1n = rn; m_s1d = rd;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        bit rn, rd, en, clr, rs;
        rn = nickel_sense; rd = dime_sense; en = enable; clr = clear_jam; rs = reset;
        @(posedge clk);
        model(rn, rd, en, clr, rs);
        #1;
        chk("coin", 32'(coin), 32'(m_coin));
        chk("reject", 32'(reject), 32'(m_rej));
        chk("jam", 32'(jam), 32'(m_jammed));
        chk("accepted_count", 32'(accepted_count), 32'(m_count));
        if (coin != 2'd0) n_coin++;
        if (reject) n_rej++;
    endtask

    task automatic do_reset();
        nickel_sense = 0; dime_sense = 0; clear_jam = 0; enable = 1;
        reset = 1;
        repeat (2) step();
        reset = 0;
        n_coin = 0; n_rej = 0;
    endtask

    task automatic insert(input bit n, input bit d, input int len, input int gap);
        nickel_sense = n; dime_sense = d;
        repeat (len) step();
        nickel_sense = 0; dime_sense = 0;
        repeat (gap) step();
    endtask

    initial begin
        // Reset state and first-coin latency
        do_reset();
        chk("reset_coin", 32'(coin), 0);
        chk("reset_jam", 32'(jam), 0);
        chk("reset_count", 32'(accepted_count), 0);
        nickel_sense = 1;
        repeat (5) step();
        chk("latency_early", 32'(coin), 0);
        step();
        chk("latency_coin", 32'(coin), 1);
        step();
        chk("coin_one_cycle", 32'(coin), 0);
        repeat (3) step();
        insert(0, 0, 0, 5);
        chk("nickel_pulses", 32'(n_coin), 1);
        chk("nickel_rejects", 32'(n_rej), 0);
        chk("nickel_count", 32'(accepted_count), 1);
        $display("txn nickel: count=%0d", accepted_count);

        // Glitch then full dime
        do_reset();
        insert(0, 1, 2, 6);
        chk("glitch_pulses", 32'(n_coin + n_rej), 0);
        insert(0, 1, 10, 5);
        chk("dime_pulses", 32'(n_coin), 1);
        chk("dime_count", 32'(accepted_count), 1);
        $display("txn glitch+dime: count=%0d", accepted_count);

        // Dual-sensor insertion, then a normal nickel
        do_reset();
        insert(1, 1, 6, 5);
        chk("dual_rejects", 32'(n_rej), 1);
        chk("dual_coins", 32'(n_coin), 0);
        insert(1, 0, 10, 5);
        chk("after_dual_count", 32'(accepted_count), 1);
        $display("txn dual+nickel: rejects=%0d count=%0d", n_rej, accepted_count);

        // Disabled acceptance
        do_reset();
        enable = 0;
        insert(1, 0, 10, 5);
        chk("disabled_rejects", 32'(n_rej), 1);
        chk("disabled_count", 32'(accepted_count), 0);
        enable = 1;
        $display("txn disabled nickel: rejects=%0d", n_rej);

        // Jam, ineffective clear while held, then proper clear
        do_reset();
        nickel_sense = 1;
        repeat (70) step();
        chk("jam_set", 32'(jam), 1);
        clear_jam = 1;
        repeat (10) step();
        clear_jam = 0;
        chk("jam_held", 32'(jam), 1);
        nickel_sense = 0;
        repeat (3) step();
        chk("jam_after_release", 32'(jam), 1);
        clear_jam = 1;
        step();
        clear_jam = 0;
        chk("jam_cleared", 32'(jam), 0);
        insert(0, 1, 10, 5);
        chk("jam_coins", 32'(n_coin), 2);
        chk("jam_count", 32'(accepted_count), 2);
        $display("txn jam: coins=%0d", n_coin);

        // Reset on the acceptance edge
        do_reset();
        nickel_sense = 1;
        repeat (5) step();
        reset = 1;
        step();
        chk("reset_acc_coin", 32'(coin), 0);
        chk("reset_acc_count", 32'(accepted_count), 0);
        reset = 0;
        nickel_sense = 0;
        repeat (4) step();
        chk("reset_acc_pulses", 32'(n_coin + n_rej), 0);
        $display("txn reset-at-accept: pulses=%0d", n_coin + n_rej);

        // Random insertions against the model
        do_reset();
        for (int e = 0; e < 80; e++) begin
            int kind;
            int len;
            int gap;
            kind = int'($urandom_range(0, 3));
            len = ($urandom_range(0, 9) == 0) ? 70 : int'($urandom_range(1, 12));
            gap = int'($urandom_range(0, 6));
            for (int c = 0; c < len; c++) begin
                nickel_sense = (kind == 0 || kind == 2);
                dime_sense = (kind == 1 || kind == 2);
                if (kind == 3) begin
                    nickel_sense = 1'($urandom_range(0, 1));
                    dime_sense = 1'($urandom_range(0, 1));
                end
                if ($urandom_range(0, 9) == 0) dime_sense = ~dime_sense;
                enable = ($urandom_range(0, 3) != 0);
                clear_jam = ($urandom_range(0, 7) == 0);
                step();
            end
            nickel_sense = 0; dime_sense = 0;
            for (int c = 0; c < gap; c++) begin
                clear_jam = 1'($urandom_range(0, 1));
                step();
            end
            $display("txn random %0d kind=%0d len=%0d count=%0d jam=%0d", e, kind, len, accepted_count, jam);
        end
        clear_jam = 0; enable = 1;

        // Counter wrap after 256 accepted nickels
        do_reset();
        for (int i = 0; i < 256; i++) insert(1, 0, 6, 4);
        chk("wrap_coins", 32'(n_coin), 256);
        chk("wrap_count", 32'(accepted_count), 0);
        $display("txn wrap: coins=%0d count=%0d", n_coin, accepted_count);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
